// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, window geometry and the
// fixed-priority helper.
package irq_pkg;

  localparam int unsigned MAX_NSRC    = 8;
  localparam int unsigned WINDOW_SIZE = 8;

  typedef enum logic [2:0] {
    RegPending = 3'd0,
    RegMask    = 3'd1,
    RegVector  = 3'd2,
    RegClaim   = 3'd3,
    RegEoi     = 3'd4
  } reg_off_e;

  // Lowest set bit wins; returns 0 for an empty vector.
  function automatic logic [7:0] lowest_index(input logic [MAX_NSRC-1:0] v);
    logic [7:0] idx;
    idx = '0;
    for (int i = int'(MAX_NSRC) - 1; i >= 0; i--) begin
      if (v[i]) idx = 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: two-flop synchroniser, history flop and single-cycle rising-edge pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic nreset,
  input  logic src,
  output logic evt
);

  logic s1_q, s2_q, s3_q;

  // Reset high so a source already asserted at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= src;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign evt = s2_q & ~s3_q;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches source edges, masks, prioritises and drives the
// CPU's IRQ/IRQn; serviced through an 8-word register window.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned NSRC      = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [NSRC-1:0] src,
  input  logic [15:0]     address,
  input  logic [31:0]     data,
  input  logic            wren,
  output logic [31:0]     rdata,
  output logic            sel,
  output logic            IRQ,
  output logic [7:0]      IRQn
);

  localparam logic [MAX_NSRC-1:0] SrcValid = {MAX_NSRC{1'b1}} >> (MAX_NSRC - NSRC);

  logic [NSRC-1:0]     evt;
  logic [MAX_NSRC-1:0] evt_all;
  logic [MAX_NSRC-1:0] pending_q, pending_d;
  logic [MAX_NSRC-1:0] mask_q, mask_d;
  logic [MAX_NSRC-1:0] active;
  logic                in_service_q, in_service_d;
  logic [7:0]          isr_num_q, isr_num_d;
  logic                irq_q, irq_d;
  logic [7:0]          irqn_q, irqn_d;
  logic [2:0]          offset;
  logic                wr;
  logic [7:0]          claim_num;
  logic                claim_ok;
  logic                unused_data;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_sync_edge u_sync (
      .clk    (clk),
      .nreset (nreset),
      .src    (src[i]),
      .evt    (evt[i])
    );
  end

  always_comb begin
    evt_all = '0;
    evt_all[NSRC-1:0] = evt;
  end

  assign sel         = (address[15:3] == BASE_ADDR[15:3]);
  assign offset      = address[2:0];
  assign wr          = sel & wren;
  assign claim_num   = data[7:0];
  assign unused_data = ^data[31:8];

  assign claim_ok = wr && (offset == RegClaim) && !in_service_q &&
                    ({24'b0, claim_num} < NSRC) &&
                    pending_q[claim_num[2:0]] && mask_q[claim_num[2:0]];

  assign active = pending_q & mask_q;

  always_comb begin
    pending_d    = pending_q;
    mask_d       = mask_q;
    in_service_d = in_service_q;
    isr_num_d    = isr_num_q;
    if (wr) begin
      case (offset)
        RegPending: pending_d    = pending_q & ~data[MAX_NSRC-1:0];
        RegMask:    mask_d       = data[MAX_NSRC-1:0] & SrcValid;
        RegEoi:     in_service_d = 1'b0;
        default: ;
      endcase
    end
    if (claim_ok) begin
      pending_d[claim_num[2:0]] = 1'b0;
      in_service_d              = 1'b1;
      isr_num_d                 = claim_num;
    end
    // Applied last so a fresh edge survives a same-cycle W1C or claim of that bit.
    pending_d = pending_d | evt_all;
    irq_d     = (active != '0) && !in_service_d;
    irqn_d    = lowest_index(active);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= 1'b0;
      isr_num_q    <= '0;
      irq_q        <= 1'b0;
      irqn_q       <= '0;
    end else begin
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      isr_num_q    <= isr_num_d;
      irq_q        <= irq_d;
      irqn_q       <= irqn_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        RegPending: rdata = {24'b0, pending_q};
        RegMask:    rdata = {24'b0, mask_q};
        RegVector:  rdata = {irq_q, 23'b0, irqn_q};
        RegClaim:   rdata = {in_service_q, 23'b0, isr_num_q};
        default: ;
      endcase
    end
  end

  assign IRQ  = irq_q;
  assign IRQn = irqn_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomised checks of irq_controller against a cycle-level behavioural model.
module tb_irq_controller;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] IDLE = 16'h0100;

  logic        clk = 1'b0;
  logic        nreset;
  logic [7:0]  src;
  logic [15:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] rdata;
  logic        sel;
  logic        IRQ;
  logic [7:0]  IRQn;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  irq_controller #(.NSRC(8), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .src     (src),
    .address (address),
    .data    (data),
    .wren    (wren),
    .rdata   (rdata),
    .sel     (sel),
    .IRQ     (IRQ),
    .IRQn    (IRQn)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] m_pend, m_mask, m_isr, m_irqn;
  logic       m_ins, m_irq;
  logic [7:0] h1, h2, h3;

  function automatic logic [7:0] lowest(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 8'(i);
    return r;
  endfunction

  function automatic logic in_window(input logic [15:0] a);
    return (a >= BASE) && (a < BASE + 16'd8);
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (!in_window(a)) return 32'h0;
    case (a - BASE)
      16'd0:   return {24'b0, m_pend};
      16'd1:   return {24'b0, m_mask};
      16'd2:   return {m_irq, 23'b0, m_irqn};
      16'd3:   return {m_ins, 23'b0, m_isr};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge nreset) begin
    logic [7:0] evt, np, nm, nisr;
    logic       ni;
    int         n;
    if (!nreset) begin
      m_pend = '0; m_mask = '0; m_isr = '0; m_ins = 1'b0; m_irq = 1'b0; m_irqn = '0;
      h1 = 8'hFF; h2 = 8'hFF; h3 = 8'hFF;
    end else begin
      // Source seen rising two edges ago and not three edges ago.
      evt = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = src;
      np = m_pend; nm = m_mask; ni = m_ins; nisr = m_isr;
      if (wren && in_window(address)) begin
        case (address - BASE)
          16'd0: np = np & ~data[7:0];
          16'd1: nm = data[7:0];
          16'd3: begin
            n = int'(data[7:0]);
            if (!m_ins && n < 8 && m_pend[n] && m_mask[n]) begin
              np[n] = 1'b0; ni = 1'b1; nisr = data[7:0];
            end
          end
          16'd4: ni = 1'b0;
          default: ;
        endcase
      end
      np = np | evt;
      m_irq  = ((m_pend & m_mask) != 0) && !ni;
      m_irqn = lowest(m_pend & m_mask);
      m_pend = np; m_mask = nm; m_ins = ni; m_isr = nisr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      check("mon_irq", {31'b0, IRQ}, {31'b0, m_irq});
      check("mon_irqn", {24'b0, IRQn}, {24'b0, m_irqn});
      check("mon_sel", {31'b0, sel}, {31'b0, in_window(address)});
      check("mon_rdata", rdata, model_read(address));
    end
  end

  // Called at a falling edge; returns at the falling edge after the write has been clocked.
  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    address = BASE + {13'b0, off};
    data    = d;
    wren    = 1'b1;
    @(negedge clk);
    wren    = 1'b0;
    address = IDLE;
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
    address = BASE + {13'b0, off};
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    logic [31:0] tmp;
    logic [15:0] a;
    nreset = 1'b0; src = 8'h04; address = IDLE; data = '0; wren = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    #1;
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("rst_irqn", {24'b0, IRQn}, 32'h0);
    rd("rst_pending", 3'd0, 32'h0);

    // Source high across reset release must not create an event.
    @(negedge clk); nreset = 1'b1;
    repeat (6) @(negedge clk);
    rd("held_pending", 3'd0, 32'h0);
    check("held_irq", {31'b0, IRQ}, 32'h0);

    // Latency of a single edge.
    @(negedge clk); wr(3'd1, 32'h04);
    src = 8'h00; repeat (4) @(negedge clk);
    src = 8'h04;
    @(negedge clk); @(negedge clk);
    rd("lat_pend_e1", 3'd0, 32'h0);
    @(negedge clk);
    rd("lat_pend_e2", 3'd0, 32'h04);
    check("lat_irq_e2", {31'b0, IRQ}, 32'h0);
    @(negedge clk);
    check("lat_irq_e3", {31'b0, IRQ}, 32'h1);
    check("lat_irqn_e3", {24'b0, IRQn}, 32'h2);
    rd("lat_vector", 3'd2, 32'h80000002);

    // Priority, claim and EOI.
    @(negedge clk); wr(3'd0, 32'h04); wr(3'd1, 32'hFF);
    src = 8'h26; repeat (5) @(negedge clk);
    check("pri_irqn", {24'b0, IRQn}, 32'h1);
    rd("pri_pend", 3'd0, 32'h22);
    @(negedge clk); wr(3'd3, 32'h1);
    check("claim_irq", {31'b0, IRQ}, 32'h0);
    rd("claim_rd", 3'd3, 32'h80000001);
    rd("claim_pend", 3'd0, 32'h20);
    @(negedge clk); wr(3'd4, 32'h0);
    check("eoi_irq", {31'b0, IRQ}, 32'h1);
    check("eoi_irqn", {24'b0, IRQn}, 32'h5);

    // Re-trigger of the in-service source is kept pending; no nesting.
    src = 8'h24; repeat (3) @(negedge clk);
    src = 8'h26; repeat (4) @(negedge clk);
    wr(3'd3, 32'h1);
    src = 8'h24; repeat (3) @(negedge clk);
    src = 8'h26; repeat (4) @(negedge clk);
    rd("retrig_pend", 3'd0, 32'h22);
    check("retrig_irq", {31'b0, IRQ}, 32'h0);
    @(negedge clk); wr(3'd4, 32'h0);
    check("retrig_eoi_irq", {31'b0, IRQ}, 32'h1);
    check("retrig_eoi_irqn", {24'b0, IRQn}, 32'h1);

    // Set beats same-cycle W1C; claim of a masked source is ignored.
    wr(3'd1, 32'hF7);
    src = 8'h2E;
    @(negedge clk); @(negedge clk);
    wr(3'd0, 32'h08);
    rd("setwins_pend", 3'd0, 32'h2A);
    @(negedge clk); wr(3'd3, 32'h3);
    rd("masked_claim", 3'd3, 32'h00000001);
    rd("masked_pend", 3'd0, 32'h2A);

    // Reset in the middle of service.
    @(negedge clk); wr(3'd0, 32'hFF); wr(3'd1, 32'hFF);
    src = 8'h00; repeat (4) @(negedge clk);
    src = 8'h0F; repeat (4) @(negedge clk);
    wr(3'd3, 32'h0);
    src = 8'h0E; repeat (3) @(negedge clk);
    src = 8'h0F; repeat (4) @(negedge clk);
    rd("pre_rst_pend", 3'd0, 32'h0F);
    rd("pre_rst_claim", 3'd3, 32'h80000000);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("mid_rst_irq", {31'b0, IRQ}, 32'h0);
    check("mid_rst_irqn", {24'b0, IRQn}, 32'h0);
    rd("mid_rst_pend", 3'd0, 32'h0);
    rd("mid_rst_mask", 3'd1, 32'h0);
    rd("mid_rst_claim", 3'd3, 32'h0);
    @(negedge clk); nreset = 1'b1; address = IDLE;

    // Randomised traffic; the monitor compares every cycle.
    for (int i = 0; i < 600; i++) begin
      nreset = (i == 300) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 1) == 1) src = src ^ 8'(1 << $urandom_range(0, 7));
      tmp  = $urandom;
      wren = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          address = BASE + 16'($urandom_range(0, 7));
          if (address == BASE + 16'd3) data = {tmp[31:8], 8'($urandom_range(0, 9))};
          else                         data = tmp;
          wren = 1'b1;
        end
        4: begin
          a = 16'($urandom);
          if (in_window(a)) a = a ^ 16'h8000;
          address = a;
          data    = tmp;
          wren    = 1'b1;
        end
        default: address = BASE + 16'($urandom_range(0, 7));
      endcase
      @(negedge clk);
    end
    wren = 1'b0; address = IDLE;
    @(negedge clk);
    mon_en = 1'b0;
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller directly upstream of the CPU core; produces the CPU's IRQ / IRQn inputs.
- Synchronises up to 8 asynchronous peripheral request lines, latches rising edges as pending events, applies a mask and fixed priority, and presents the winning request.
- Software services it over the CPU's RAM bus through an 8-word register window.
- An external bus mux returns rdata to the CPU's q input whenever sel is high.

Parameters:
- NSRC, 8, number of interrupt sources (1..8).
- BASE_ADDR, 16'hFF00, word address of register window; must be 8-word aligned.

Ports:
- clk  input  1  system clock.
- nreset  input  1  asynchronous active-low reset.
- src  input  NSRC  asynchronous peripheral requests, rising-edge triggered.
- address  input  16  CPU word address.
- data  input  32  CPU write data.
- wren  input  1  CPU write enable.
- rdata  output  32  read data for the window (combinational).
- sel  output  1  high when address falls in [BASE_ADDR, BASE_ADDR+7] (combinational).
- IRQ  output  1  registered interrupt request to CPU.
- IRQn  output  8  registered interrupt number to CPU.

Behaviour:
- Reset (async, nreset=0):
  - pending=0, mask=0, in_service=0, isr_num=0, IRQ=0, IRQn=0.
  - All synchroniser/edge flops reset to 1, so a source already high at reset release does not create an event.
- Per source: 2-flop synchroniser s1→s2, then history flop s3; event = s2 & ~s3.
- Latency: src rises before edge E0 → pending bit set at E0+2 → IRQ/IRQn valid at E0+3.
- Register map (offset from BASE_ADDR; reads side-effect free; writes take effect on the clk edge where sel && wren):
  - 0 PENDING: read pending (zero-extended); write 1s clear matching bits (W1C).
  - 1 MASK: R/W, bits [NSRC-1:0]; 1 = enabled; upper bits read 0.
  - 2 VECTOR: RO; {IRQ, 23'b0, IRQn}.
  - 3 CLAIM: write data[7:0]=n.
    - If !in_service, n<NSRC, and pending[n]&mask[n]: clear pending[n], set in_service, isr_num=n.
    - Otherwise the write is ignored.
    - Read returns {in_service, 23'b0, isr_num}.
  - 4 EOI: any write clears in_service; reads 0.
  - 5-7: read 0; writes ignored.
- All writes are idempotent, so wren held over several cycles (CPU stall) is harmless.
- Request generation, updated every cycle:
  - active = pending & mask.
  - IRQ <= (active != 0) && !in_service_next.
  - IRQn <= index of lowest set bit of active, 0 if none.
  - Lowest index has highest priority.
- Boundary conditions:
  - New event and W1C on the same bit in the same cycle: set wins.
  - New event on an in-service source while in_service: the bit becomes pending again and is not lost.
  - Claim and EOI cannot coincide (single bus).
  - The event for a claimed bit that arrives in the claim cycle remains pending.
  - A masked pending bit stays pending; unmasking it raises IRQ on the next cycle.
  - Repeated edges while pending collapse to a single event.
  - No nesting: IRQ is held low while in_service, regardless of pending.
  - Reset mid-operation discards all pending and in-service state immediately.
- Addresses outside the window: sel=0, rdata=0, no state change.

Decomposition:
- Shared package irq_pkg: register offsets (PENDING=0, MASK=1, VECTOR=2, CLAIM=3, EOI=4), window size 8, max NSRC 8.
- Sub-module irq_sync_edge: one source's synchroniser, history flop and event pulse; instantiated NSRC times.
- Priority encoder and register file stay in the top.

Test Plan:
- Reset, then hold src[2]=1 from release → PENDING reads 0 forever; IRQ=0.
- MASK=0x04; pulse src[2] at edge E0 → PENDING=0x04 at E0+2; IRQ=1, IRQn=2 at E0+3; VECTOR reads 0x80000002.
- MASK=0xFF; raise src[5] and src[1] together → IRQn=1; CLAIM 1 → IRQ=0, CLAIM reads 0x80000001, PENDING=0x20; EOI → IRQ=1, IRQn=5.
- While in_service=1 (isr 1), pulse src[1] again → PENDING bit1 set, IRQ stays 0; EOI → IRQ=1, IRQn=1.
- Write PENDING=0x08 in the same cycle src[3]'s event fires → PENDING bit3 remains 1. CLAIM 3 while MASK bit3=0 → ignored, in_service=0.
- Assert nreset low mid-service with PENDING=0x0F → immediately IRQ=0, IRQn=0, PENDING=0, MASK=0, CLAIM reads 0.
